// File: rtl/simt_stack_ctrl_if.sv
// Request/stack/response signal bundle for one SIMT reconvergence sequencer.
interface simt_stack_ctrl_if #(
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_THREAD = 8
);
   logic                  flush_i;
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_type_i;
   logic [31:0]           req_pc_i;
   logic [31:0]           req_jump_pc_i;
   logic [31:0]           req_else_pc_i;
   logic [31:0]           req_recon_pc_i;
   logic [NUM_THREAD-1:0] req_taken_mask_i;
   logic [NUM_THREAD-1:0] req_active_mask_i;
   logic                  stk_push_o;
   logic                  stk_pop_o;
   logic [31:0]           stk_recon_pc_o;
   logic [31:0]           stk_jump_pc_o;
   logic [NUM_THREAD-1:0] stk_new_mask_o;
   logic [NUM_THREAD-1:0] stk_thread_mask_o;
   logic [31:0]           stk_pc_execute_o;
   logic                  stk_jump_i;
   logic [31:0]           stk_new_pc_i;
   logic [NUM_THREAD-1:0] stk_new_mask_i;
   logic                  stk_empty_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic                  rsp_redirect_o;
   logic [31:0]           rsp_pc_o;
   logic [NUM_THREAD-1:0] rsp_mask_o;
   logic [ADDR_WIDTH:0]   occupancy_o;
   logic                  err_overflow_o;
   logic                  err_underflow_o;

   modport slave (
      input  flush_i, req_valid_i, req_type_i, req_pc_i, req_jump_pc_i, req_else_pc_i,
             req_recon_pc_i, req_taken_mask_i, req_active_mask_i,
             stk_jump_i, stk_new_pc_i, stk_new_mask_i, stk_empty_i, rsp_ready_i,
      output req_ready_o, stk_push_o, stk_pop_o, stk_recon_pc_o, stk_jump_pc_o,
             stk_new_mask_o, stk_thread_mask_o, stk_pc_execute_o,
             rsp_valid_o, rsp_redirect_o, rsp_pc_o, rsp_mask_o,
             occupancy_o, err_overflow_o, err_underflow_o
   );

   modport master (
      output flush_i, req_valid_i, req_type_i, req_pc_i, req_jump_pc_i, req_else_pc_i,
             req_recon_pc_i, req_taken_mask_i, req_active_mask_i,
             stk_jump_i, stk_new_pc_i, stk_new_mask_i, stk_empty_i, rsp_ready_i,
      input  req_ready_o, stk_push_o, stk_pop_o, stk_recon_pc_o, stk_jump_pc_o,
             stk_new_mask_o, stk_thread_mask_o, stk_pc_execute_o,
             rsp_valid_o, rsp_redirect_o, rsp_pc_o, rsp_mask_o,
             occupancy_o, err_overflow_o, err_underflow_o
   );
endinterface

// File: rtl/simt_stack_ctrl.sv
// Per-warp branch/join sequencer: classifies branches, strobes the
// reconvergence stack, and returns a PC/mask redirect to the scheduler.
module simt_stack_ctrl #(
   parameter int ADDR_WIDTH = 2,
   parameter int NUM_THREAD = 8
) (
   input  logic               clk,
   input  logic               rst,
   simt_stack_ctrl_if.slave   bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   // A divergent push consumes two entries (reconvergence + deferred path).
   localparam logic [ADDR_WIDTH:0] OCC_PUSH_MAX = (ADDR_WIDTH+1)'(DEPTH-2);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_type;
   logic [31:0]           r_pc, r_jump_pc, r_else_pc, r_recon_pc;
   logic [NUM_THREAD-1:0] r_taken, r_active;
   logic [ADDR_WIDTH:0]   r_occ, w_occ_nxt;
   logic                  r_ovf, r_unf;
   logic                  r_rsp_redirect;
   logic [31:0]           r_rsp_pc;
   logic [NUM_THREAD-1:0] r_rsp_mask;

   logic                  w_ready, w_push, w_pop, w_redirect, w_set_ovf, w_set_unf;
   logic [31:0]           w_pc;
   logic [NUM_THREAD-1:0] w_mask, w_t, w_e;

   assign w_t     = r_taken & r_active;
   assign w_e     = ~r_taken & r_active;
   assign w_ready = (r_state == S_IDLE) && !rst;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state, branch classification, stack strobes and occupancy update.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_redirect  = 1'b0;
      w_pc        = '0;
      w_mask      = '0;
      w_occ_nxt   = r_occ;
      w_set_ovf   = 1'b0;
      w_set_unf   = 1'b0;
      case (r_state)
         S_IDLE: if (bus.req_valid_i) w_state_nxt = S_EXEC;
         S_EXEC: begin
            w_state_nxt = S_RESP;
            if (!r_type) begin
               w_redirect = 1'b1;
               if (w_t == '0) begin
                  w_pc   = r_else_pc;
                  w_mask = r_active;
               end else if (w_t == r_active) begin
                  w_pc   = r_jump_pc;
                  w_mask = r_active;
               end else if (r_occ <= OCC_PUSH_MAX) begin
                  w_push    = 1'b1;
                  w_occ_nxt = r_occ + (ADDR_WIDTH+1)'(2);
                  w_pc      = r_jump_pc;
                  w_mask    = w_t;
               end else begin
                  // No room: run the whole warp down the taken path.
                  w_set_ovf = 1'b1;
                  w_pc      = r_jump_pc;
                  w_mask    = r_active;
               end
            end else begin
               w_pop = 1'b1;
               if (bus.stk_jump_i) begin
                  w_redirect = 1'b1;
                  w_pc       = bus.stk_new_pc_i;
                  w_mask     = bus.stk_new_mask_i;
               end
               if (bus.stk_empty_i)
                  w_set_unf = 1'b1;
               else if (bus.stk_jump_i && r_occ != '0)
                  w_occ_nxt = r_occ - (ADDR_WIDTH+1)'(1);
            end
         end
         S_RESP: if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
      // Flush abandons the request without touching stack bookkeeping.
      if (bus.flush_i || rst) begin
         w_state_nxt = S_IDLE;
         w_push      = 1'b0;
         w_pop       = 1'b0;
         w_occ_nxt   = r_occ;
         w_set_ovf   = 1'b0;
         w_set_unf   = 1'b0;
      end
   end

   // Request capture, occupancy/error tracking and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_type         <= 1'b0;
         r_pc           <= '0;
         r_jump_pc      <= '0;
         r_else_pc      <= '0;
         r_recon_pc     <= '0;
         r_taken        <= '0;
         r_active       <= '0;
         r_occ          <= '0;
         r_ovf          <= 1'b0;
         r_unf          <= 1'b0;
         r_rsp_redirect <= 1'b0;
         r_rsp_pc       <= '0;
         r_rsp_mask     <= '0;
      end else begin
         if (w_ready && bus.req_valid_i && !bus.flush_i) begin
            r_type     <= bus.req_type_i;
            r_pc       <= bus.req_pc_i;
            r_jump_pc  <= bus.req_jump_pc_i;
            r_else_pc  <= bus.req_else_pc_i;
            r_recon_pc <= bus.req_recon_pc_i;
            r_taken    <= bus.req_taken_mask_i;
            r_active   <= bus.req_active_mask_i;
         end
         r_occ <= w_occ_nxt;
         if (w_set_ovf) r_ovf <= 1'b1;
         if (w_set_unf) r_unf <= 1'b1;
         if (r_state == S_EXEC && !bus.flush_i) begin
            r_rsp_redirect <= w_redirect;
            r_rsp_pc       <= w_pc;
            r_rsp_mask     <= w_mask;
         end
      end
   end

   assign bus.req_ready_o       = w_ready;
   assign bus.stk_push_o        = w_push;
   assign bus.stk_pop_o         = w_pop;
   assign bus.stk_recon_pc_o    = w_push ? r_recon_pc : '0;
   assign bus.stk_jump_pc_o     = w_push ? r_else_pc  : '0;
   assign bus.stk_new_mask_o    = w_push ? w_e        : '0;
   assign bus.stk_thread_mask_o = w_push ? r_active   : '0;
   assign bus.stk_pc_execute_o  = w_pop  ? r_pc       : '0;
   assign bus.rsp_valid_o       = (r_state == S_RESP) && !rst;
   assign bus.rsp_redirect_o    = r_rsp_redirect;
   assign bus.rsp_pc_o          = r_rsp_pc;
   assign bus.rsp_mask_o        = r_rsp_mask;
   assign bus.occupancy_o       = r_occ;
   assign bus.err_overflow_o    = r_ovf;
   assign bus.err_underflow_o   = r_unf;
endmodule

// File: tb/tb_simt_stack_ctrl.sv
// Directed bench for simt_stack_ctrl with hand-computed expectations.
module tb_simt_stack_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   simt_stack_ctrl_if #(.ADDR_WIDTH(2), .NUM_THREAD(8)) bus();
   simt_stack_ctrl #(.ADDR_WIDTH(2), .NUM_THREAD(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Present one request in IDLE and advance into the EXEC cycle.
   task automatic issue(input logic typ, input logic [31:0] pc, jmp, els, rec,
                        input logic [7:0] tk, act);
      bus.req_valid_i       = 1'b1;
      bus.req_type_i        = typ;
      bus.req_pc_i          = pc;
      bus.req_jump_pc_i     = jmp;
      bus.req_else_pc_i     = els;
      bus.req_recon_pc_i    = rec;
      bus.req_taken_mask_i  = tk;
      bus.req_active_mask_i = act;
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
   endtask

   // Accept the pending response.
   task automatic take_rsp();
      bus.rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic set_stub(input logic jmp, input logic [31:0] pc, input logic [7:0] m, input logic emp);
      bus.stk_jump_i     = jmp;
      bus.stk_new_pc_i   = pc;
      bus.stk_new_mask_i = m;
      bus.stk_empty_i    = emp;
   endtask

   task automatic test_reset();
      bus.flush_i = 0; bus.req_valid_i = 0; bus.req_type_i = 0; bus.req_pc_i = 0;
      bus.req_jump_pc_i = 0; bus.req_else_pc_i = 0; bus.req_recon_pc_i = 0;
      bus.req_taken_mask_i = 0; bus.req_active_mask_i = 0; bus.rsp_ready_i = 0;
      set_stub(1'b0, 32'h0, 8'h00, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %0h exp 0", bus.req_ready_o); end
      n_cmp++; if (bus.rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0h exp 0", bus.rsp_valid_o); end
      n_cmp++; if (bus.occupancy_o !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d exp 0", bus.occupancy_o); end
      n_cmp++; if ({bus.err_overflow_o, bus.err_underflow_o} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b exp 00", {bus.err_overflow_o, bus.err_underflow_o}); end
      n_cmp++; if ({bus.stk_push_o, bus.stk_pop_o} !== 2'b00) begin n_err++; $display("FAIL reset_strobe got %b exp 00", {bus.stk_push_o, bus.stk_pop_o}); end
      rst = 1'b0; #1;
      n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL idle_ready got %0h exp 1", bus.req_ready_o); end
   endtask

   task automatic test_uniform();
      issue(1'b0, 32'h50, 32'h100, 32'h104, 32'h300, 8'hFF, 8'hFF);
      n_cmp++; if (bus.stk_push_o !== 1'b0) begin n_err++; $display("FAIL uni_push got %0h exp 0", bus.stk_push_o); end
      n_cmp++; if (bus.req_ready_o !== 1'b0) begin n_err++; $display("FAIL uni_ready got %0h exp 0", bus.req_ready_o); end
      @(posedge clk); #1;
      n_cmp++; if (bus.rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL uni_valid got %0h exp 1", bus.rsp_valid_o); end
      n_cmp++; if ({bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o} !== {1'b1, 32'h100, 8'hFF}) begin n_err++; $display("FAIL uni_rsp got %0h/%0h/%0h exp 1/100/ff", bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o); end
      n_cmp++; if (bus.occupancy_o !== 3'd0) begin n_err++; $display("FAIL uni_occ got %0d exp 0", bus.occupancy_o); end
      take_rsp();
      n_cmp++; if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin n_err++; $display("FAIL uni_done got %b exp 01", {bus.rsp_valid_o, bus.req_ready_o}); end
   endtask

   task automatic test_none_taken();
      issue(1'b0, 32'h54, 32'h100, 32'h104, 32'h300, 8'h00, 8'hFF);
      n_cmp++; if (bus.stk_push_o !== 1'b0) begin n_err++; $display("FAIL nt_push got %0h exp 0", bus.stk_push_o); end
      @(posedge clk); #1;
      n_cmp++; if ({bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o} !== {1'b1, 32'h104, 8'hFF}) begin n_err++; $display("FAIL nt_rsp got %0h/%0h/%0h exp 1/104/ff", bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o); end
      take_rsp();
   endtask

   task automatic test_divergent();
      issue(1'b0, 32'h60, 32'h200, 32'h104, 32'h300, 8'h0F, 8'hFF);
      n_cmp++; if ({bus.stk_push_o, bus.stk_pop_o} !== 2'b10) begin n_err++; $display("FAIL div_strobe got %b exp 10", {bus.stk_push_o, bus.stk_pop_o}); end
      n_cmp++; if ({bus.stk_new_mask_o, bus.stk_thread_mask_o} !== {8'hF0, 8'hFF}) begin n_err++; $display("FAIL div_masks got %0h/%0h exp f0/ff", bus.stk_new_mask_o, bus.stk_thread_mask_o); end
      n_cmp++; if ({bus.stk_jump_pc_o, bus.stk_recon_pc_o} !== {32'h104, 32'h300}) begin n_err++; $display("FAIL div_pcs got %0h/%0h exp 104/300", bus.stk_jump_pc_o, bus.stk_recon_pc_o); end
      @(posedge clk); #1;
      n_cmp++; if (bus.stk_push_o !== 1'b0) begin n_err++; $display("FAIL div_pulse got %0h exp 0", bus.stk_push_o); end
      n_cmp++; if ({bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o} !== {1'b1, 32'h200, 8'h0F}) begin n_err++; $display("FAIL div_rsp got %0h/%0h/%0h exp 1/200/0f", bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o); end
      n_cmp++; if (bus.occupancy_o !== 3'd2) begin n_err++; $display("FAIL div_occ got %0d exp 2", bus.occupancy_o); end
      take_rsp();
   endtask

   task automatic test_join();
      set_stub(1'b1, 32'h104, 8'hF0, 1'b0);
      issue(1'b1, 32'h300, 32'h0, 32'h0, 32'h0, 8'h00, 8'h0F);
      n_cmp++; if ({bus.stk_push_o, bus.stk_pop_o} !== 2'b01) begin n_err++; $display("FAIL join_strobe got %b exp 01", {bus.stk_push_o, bus.stk_pop_o}); end
      n_cmp++; if (bus.stk_pc_execute_o !== 32'h300) begin n_err++; $display("FAIL join_pcx got %0h exp 300", bus.stk_pc_execute_o); end
      @(posedge clk); #1;
      n_cmp++; if (bus.stk_pop_o !== 1'b0) begin n_err++; $display("FAIL join_pulse got %0h exp 0", bus.stk_pop_o); end
      n_cmp++; if ({bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o} !== {1'b1, 32'h104, 8'hF0}) begin n_err++; $display("FAIL join_rsp got %0h/%0h/%0h exp 1/104/f0", bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o); end
      n_cmp++; if (bus.occupancy_o !== 3'd1) begin n_err++; $display("FAIL join_occ got %0d exp 1", bus.occupancy_o); end
      take_rsp();
      set_stub(1'b0, 32'h0, 8'h00, 1'b0);
   endtask

   task automatic test_overflow();
      issue(1'b0, 32'h70, 32'h200, 32'h104, 32'h300, 8'h0F, 8'hFF);
      n_cmp++; if (bus.stk_push_o !== 1'b1) begin n_err++; $display("FAIL ovf1_push got %0h exp 1", bus.stk_push_o); end
      @(posedge clk); #1;
      n_cmp++; if ({bus.occupancy_o, bus.err_overflow_o} !== {3'd3, 1'b0}) begin n_err++; $display("FAIL ovf1_state got %0d/%0h exp 3/0", bus.occupancy_o, bus.err_overflow_o); end
      take_rsp();
      issue(1'b0, 32'h74, 32'h220, 32'h108, 32'h320, 8'h3C, 8'hFF);
      n_cmp++; if (bus.stk_push_o !== 1'b0) begin n_err++; $display("FAIL ovf2_push got %0h exp 0", bus.stk_push_o); end
      @(posedge clk); #1;
      n_cmp++; if (bus.err_overflow_o !== 1'b1) begin n_err++; $display("FAIL ovf2_flag got %0h exp 1", bus.err_overflow_o); end
      n_cmp++; if ({bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o} !== {1'b1, 32'h220, 8'hFF}) begin n_err++; $display("FAIL ovf2_rsp got %0h/%0h/%0h exp 1/220/ff", bus.rsp_redirect_o, bus.rsp_pc_o, bus.rsp_mask_o); end
      n_cmp++; if (bus.occupancy_o !== 3'd3) begin n_err++; $display("FAIL ovf2_occ got %0d exp 3", bus.occupancy_o); end
      take_rsp();
   endtask

   task automatic test_backpressure_flush();
      issue(1'b0, 32'h80, 32'h400, 32'h404, 32'h500, 8'hAA, 8'hAA);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_pc_o, bus.rsp_mask_o} !== {2'b10, 32'h400, 8'hAA}) begin n_err++; $display("FAIL bp_hold%0d got %b/%0h/%0h exp 10/400/aa", i, {bus.rsp_valid_o, bus.req_ready_o}, bus.rsp_pc_o, bus.rsp_mask_o); end
         @(posedge clk); #1;
      end
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      n_cmp++; if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin n_err++; $display("FAIL flush_rsp got %b exp 01", {bus.rsp_valid_o, bus.req_ready_o}); end
      n_cmp++; if ({bus.occupancy_o, bus.err_overflow_o} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL flush_keep got %0d/%0h exp 3/1", bus.occupancy_o, bus.err_overflow_o); end
      // Flush landing on the EXEC cycle of a join that would pop.
      set_stub(1'b1, 32'h600, 8'h11, 1'b0);
      issue(1'b1, 32'h500, 32'h0, 32'h0, 32'h0, 8'h00, 8'hFF);
      bus.flush_i = 1'b1; #1;
      n_cmp++; if ({bus.stk_push_o, bus.stk_pop_o, bus.stk_pc_execute_o} !== {2'b00, 32'h0}) begin n_err++; $display("FAIL flush_exec_strobe got %b/%0h exp 00/0", {bus.stk_push_o, bus.stk_pop_o}, bus.stk_pc_execute_o); end
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      n_cmp++; if ({bus.rsp_valid_o, bus.req_ready_o, bus.occupancy_o} !== {2'b01, 3'd3}) begin n_err++; $display("FAIL flush_exec_after got %b/%0d exp 01/3", {bus.rsp_valid_o, bus.req_ready_o}, bus.occupancy_o); end
      set_stub(1'b0, 32'h0, 8'h00, 1'b0);
      // Reset while a response is waiting.
      issue(1'b0, 32'h90, 32'h700, 32'h704, 32'h800, 8'hFF, 8'hFF);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_redirect_o} !== 3'b000) begin n_err++; $display("FAIL rst_ctl got %b exp 000", {bus.req_ready_o, bus.rsp_valid_o, bus.rsp_redirect_o}); end
      n_cmp++; if ({bus.rsp_pc_o, bus.rsp_mask_o} !== {32'h0, 8'h00}) begin n_err++; $display("FAIL rst_rsp got %0h/%0h exp 0/0", bus.rsp_pc_o, bus.rsp_mask_o); end
      n_cmp++; if ({bus.occupancy_o, bus.err_overflow_o, bus.err_underflow_o} !== {3'd0, 2'b00}) begin n_err++; $display("FAIL rst_state got %0d/%b exp 0/00", bus.occupancy_o, {bus.err_overflow_o, bus.err_underflow_o}); end
      rst = 1'b0;
   endtask

   task automatic test_underflow();
      set_stub(1'b0, 32'h0, 8'h00, 1'b1);
      issue(1'b1, 32'hA00, 32'h0, 32'h0, 32'h0, 8'h00, 8'h0F);
      n_cmp++; if (bus.stk_pop_o !== 1'b1) begin n_err++; $display("FAIL unf_pop got %0h exp 1", bus.stk_pop_o); end
      @(posedge clk); #1;
      n_cmp++; if ({bus.rsp_valid_o, bus.rsp_redirect_o} !== 2'b10) begin n_err++; $display("FAIL unf_rsp got %b exp 10", {bus.rsp_valid_o, bus.rsp_redirect_o}); end
      n_cmp++; if ({bus.err_underflow_o, bus.occupancy_o} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL unf_state got %0h/%0d exp 1/0", bus.err_underflow_o, bus.occupancy_o); end
      take_rsp();
      set_stub(1'b0, 32'h0, 8'h00, 1'b0);
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_none_taken();
      test_divergent();
      test_join();
      test_overflow();
      test_backpressure_flush();
      test_underflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
